// File: rtl/dm_cache_ctrl_if.sv
// CPU word port plus main_memory block port of the direct-mapped cache.
// slave is the cache's view; master is the CPU/memory side driving it.
interface dm_cache_ctrl_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_BYTES = 32
);
    logic [ADDR_WIDTH-1:0]    cpu_addr;
    logic [31:0]              cpu_wdata;
    logic                     cpu_read;
    logic                     cpu_write;
    logic [31:0]              cpu_rdata;
    logic                     cpu_ready;

    logic [ADDR_WIDTH-1:0]    mem_addr_block;
    logic [BLOCK_BYTES*8-1:0] mem_wdata_block;
    logic                     mem_read;
    logic                     mem_write;
    logic [BLOCK_BYTES*8-1:0] mem_rdata_block;
    logic                     mem_ready;

    logic [15:0]              hit_count;
    logic [15:0]              miss_count;

    modport master (
        output cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata_block, mem_ready,
        input  cpu_rdata, cpu_ready, mem_addr_block, mem_wdata_block, mem_read, mem_write,
        input  hit_count, miss_count
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read, cpu_write, mem_rdata_block, mem_ready,
        output cpu_rdata, cpu_ready, mem_addr_block, mem_wdata_block, mem_read, mem_write,
        output hit_count, miss_count
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache; hit completes 2 edges after request, misses add
// writeback/fill round trips. CPU holds its request until the one-cycle cpu_ready pulse.
module dm_cache_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_BYTES = 32,
    parameter int NUM_LINES   = 8
) (
    input logic            clk,
    input logic            rst,
    dm_cache_ctrl_if.slave bus
);
    localparam int OFFSET_BITS = $clog2(BLOCK_BYTES);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int WORD_BITS   = OFFSET_BITS - 2;
    localparam int LINE_BITS   = BLOCK_BYTES * 8;
    localparam int LSB_BITS    = $clog2(LINE_BITS);

    typedef enum logic [2:0] {
        IDLE,
        TAG_CHECK,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:2]   req_addr;
    logic [31:0]             req_wdata;
    logic                    req_write;
    logic                    refill;
    logic [NUM_LINES-1:0]    valid;
    logic [NUM_LINES-1:0]    dirty;

    logic [TAG_BITS-1:0]     tags  [NUM_LINES];
    logic [LINE_BITS-1:0]    lines [NUM_LINES];

    logic [WORD_BITS-1:0]    req_word;
    logic [INDEX_BITS-1:0]   req_index;
    logic [TAG_BITS-1:0]     req_tag;
    logic [LSB_BITS-1:0]     word_lsb;
    logic [LINE_BITS-1:0]    cur_line;
    logic [TAG_BITS-1:0]     cur_tag;
    logic [31:0]             cur_word;
    logic                    hit;
    logic                    hit_wr_en;
    logic                    fill_en;
    logic                    unused_byte_sel;

    localparam logic [OFFSET_BITS-1:0] BLK_ZERO = '0;

    assign req_word  = req_addr[OFFSET_BITS-1:2];
    assign req_index = req_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
    assign req_tag   = req_addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
    assign word_lsb  = {req_word, 5'd0};
    assign cur_line  = lines[req_index];
    assign cur_tag   = tags[req_index];
    assign cur_word  = cur_line[word_lsb +: 32];
    assign hit       = valid[req_index] && (cur_tag == req_tag);
    assign hit_wr_en = (state == TAG_CHECK) && hit && req_write;
    assign fill_en   = (state == FILL_WAIT) && bus.mem_ready;

    // Byte select within a word has no meaning for a word-only port.
    assign unused_byte_sel = &{1'b0, bus.cpu_addr[1:0]};

    // Line storage carries no reset so it can map onto plain RAM; the valid bits gate its use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            lines[req_index] <= bus.mem_rdata_block;
            tags[req_index]  <= req_tag;
        end else if (hit_wr_en) begin
            lines[req_index][word_lsb +: 32] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            req_addr            <= '0;
            req_wdata           <= '0;
            req_write           <= 1'b0;
            refill              <= 1'b0;
            valid               <= '0;
            dirty               <= '0;
            bus.cpu_rdata       <= '0;
            bus.cpu_ready       <= 1'b0;
            bus.mem_addr_block  <= '0;
            bus.mem_wdata_block <= '0;
            bus.mem_read        <= 1'b0;
            bus.mem_write       <= 1'b0;
            bus.hit_count       <= '0;
            bus.miss_count      <= '0;
        end else begin
            bus.cpu_ready <= 1'b0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            case (state)
                IDLE: begin
                    // A request still held during the completion cycle belongs to the finished access.
                    if (!bus.cpu_ready && (bus.cpu_read || bus.cpu_write)) begin
                        req_addr  <= bus.cpu_addr[ADDR_WIDTH-1:2];
                        req_wdata <= bus.cpu_wdata;
                        req_write <= bus.cpu_write;
                        state     <= TAG_CHECK;
                    end
                end
                TAG_CHECK: begin
                    if (hit) begin
                        if (req_write) begin
                            dirty[req_index] <= 1'b1;
                        end else begin
                            bus.cpu_rdata <= cur_word;
                        end
                        bus.cpu_ready <= 1'b1;
                        // The check that follows a fill was already counted as a miss.
                        if (!refill && (bus.hit_count != 16'hFFFF)) begin
                            bus.hit_count <= bus.hit_count + 16'd1;
                        end
                        refill <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        if (bus.miss_count != 16'hFFFF) begin
                            bus.miss_count <= bus.miss_count + 16'd1;
                        end
                        if (valid[req_index] && dirty[req_index]) begin
                            bus.mem_write       <= 1'b1;
                            bus.mem_addr_block  <= {cur_tag, req_index, BLK_ZERO};
                            bus.mem_wdata_block <= cur_line;
                            state               <= WB_REQ;
                        end else begin
                            bus.mem_read       <= 1'b1;
                            bus.mem_addr_block <= {req_tag, req_index, BLK_ZERO};
                            state              <= FILL_REQ;
                        end
                    end
                end
                WB_REQ: begin
                    state <= WB_WAIT;
                end
                WB_WAIT: begin
                    if (bus.mem_ready) begin
                        dirty[req_index]   <= 1'b0;
                        bus.mem_read       <= 1'b1;
                        bus.mem_addr_block <= {req_tag, req_index, BLK_ZERO};
                        state              <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    state <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (bus.mem_ready) begin
                        valid[req_index] <= 1'b1;
                        dirty[req_index] <= 1'b0;
                        refill           <= 1'b1;
                        state            <= TAG_CHECK;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: CPU driver with a flat word reference model, a block memory
// responder with expected-transaction queue, and a cpu_ready monitor popping expected read data.
module tb_dm_cache_ctrl;
    localparam int AW      = 16;
    localparam int BB      = 32;
    localparam int LB      = BB * 8;
    localparam int MEM_LAT = 3;

    logic clk;
    logic rst;

    dm_cache_ctrl_if #(.ADDR_WIDTH(AW), .BLOCK_BYTES(BB)) bus ();

    dm_cache_ctrl #(.ADDR_WIDTH(AW), .BLOCK_BYTES(BB), .NUM_LINES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_read;
        logic [31:0] data;
        string       tag;
    } cpu_exp_t;

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
    } mem_exp_t;

    cpu_exp_t        cpu_q[$];
    mem_exp_t        mem_q[$];
    logic [31:0]     ref_mem [16384];
    logic [LB-1:0]   mem_blk [2048];
    logic [LB-1:0]   last_wb;
    int              vec_cnt = 0;
    int              err_cnt = 0;
    int              cyc = 0;
    int              pulse_cnt = 0;
    int              pulse_cyc[$];

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // Completion monitor: every cpu_ready pulse must match the oldest outstanding request.
    initial begin : cpu_mon
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.cpu_ready) begin
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
                if (cpu_q.size() == 0) begin
                    check("unexp_ready", LB'(bus.cpu_ready), '0);
                end else begin
                    e = cpu_q.pop_front();
                    if (e.is_read) check(e.tag, LB'(bus.cpu_rdata), LB'(e.data));
                end
            end
        end
    end

    // Block memory: accepts one request at a time and answers MEM_LAT cycles later.
    initial begin : mem_sim
        int            cnt;
        logic          busy;
        logic          op_wr;
        logic [AW-1:0] op_addr;
        logic [LB-1:0] wb_data;
        mem_exp_t      m;
        busy = 1'b0;
        cnt  = 0;
        op_wr = 1'b0;
        op_addr = '0;
        wb_data = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata_block = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (rst) begin
                busy = 1'b0;
            end else if (busy) begin
                if (bus.mem_read || bus.mem_write)
                    check("mem_overlap", LB'({bus.mem_write, bus.mem_read}), '0);
                if (cnt == 0) begin
                    if (op_wr) begin
                        check("wb_hold", bus.mem_wdata_block, wb_data);
                        mem_blk[op_addr[AW-1:5]] = wb_data;
                    end else begin
                        bus.mem_rdata_block = mem_blk[op_addr[AW-1:5]];
                    end
                    bus.mem_ready = 1'b1;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (bus.mem_read || bus.mem_write) begin
                check("mem_excl", LB'(bus.mem_read & bus.mem_write), '0);
                if (mem_q.size() == 0) begin
                    check("unexp_mem", LB'({bus.mem_write, bus.mem_read}), '0);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_op", LB'(bus.mem_write), LB'(m.is_wr));
                    check("mem_addr", LB'(bus.mem_addr_block), LB'(m.addr));
                end
                op_wr   = bus.mem_write;
                op_addr = bus.mem_addr_block;
                if (op_wr) begin
                    wb_data = bus.mem_wdata_block;
                    last_wb = wb_data;
                end
                busy = 1'b1;
                cnt  = MEM_LAT;
            end
        end
    end

    task automatic push_mem(input logic is_wr, input logic [AW-1:0] addr);
        mem_exp_t m;
        m.is_wr = is_wr;
        m.addr  = addr;
        mem_q.push_back(m);
    endtask

    task automatic cpu_op(input logic rd, input logic wr, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input string tag, output int lat);
        cpu_exp_t e;
        @(negedge clk);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        bus.cpu_read  = rd;
        bus.cpu_write = wr;
        e.is_read = !wr;
        e.data    = ref_mem[addr[AW-1:2]];
        e.tag     = tag;
        if (wr) ref_mem[addr[AW-1:2]] = wd;
        cpu_q.push_back(e);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.cpu_ready) break;
            if (lat >= 200) begin
                check({"tmo_", tag}, LB'(bus.cpu_ready), LB'(1));
                break;
            end
        end
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, LB'(bus.cpu_ready), '0);
        check({tag, "_rdata"}, LB'(bus.cpu_rdata), '0);
        check({tag, "_mrd"},   LB'({bus.mem_read, bus.mem_write}), '0);
        check({tag, "_maddr"}, LB'(bus.mem_addr_block), '0);
        check({tag, "_mwdat"}, bus.mem_wdata_block, '0);
        check({tag, "_cnt"},   LB'({bus.hit_count, bus.miss_count}), '0);
    endtask

    initial begin : main
        int lat;
        int p0;
        int s0;
        rst = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        last_wb = '0;
        for (int b = 0; b < 2048; b++) begin
            for (int w = 0; w < 8; w++) begin
                mem_blk[b][w*32 +: 32] = 32'h1000_0000 + 32'(b);
                ref_mem[b*8 + w]       = 32'h1000_0000 + 32'(b);
            end
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // T1: clean read miss fills block 0x0040
        push_mem(1'b0, 16'h0040);
        cpu_op(1'b1, 1'b0, 16'h0040, 32'h0, "t1_rd", lat);
        check("t1_rdata", LB'(bus.cpu_rdata), LB'(32'h1000_0002));
        check("t1_cnt", LB'({bus.hit_count, bus.miss_count}), LB'({16'd0, 16'd1}));
        check("t1_memq", LB'(mem_q.size()), '0);

        // T2: same block, pure hit
        cpu_op(1'b1, 1'b0, 16'h0044, 32'h0, "t2_rd", lat);
        check("t2_lat", LB'(lat), LB'(2));
        check("t2_rdata", LB'(bus.cpu_rdata), LB'(32'h1000_0002));
        check("t2_hits", LB'(bus.hit_count), LB'(1));

        // T3: dirty the line, then evict it with a conflicting read
        cpu_op(1'b0, 1'b1, 16'h0048, 32'hDEAD_BEEF, "t3_wr", lat);
        check("t3_wr_lat", LB'(lat), LB'(2));
        push_mem(1'b1, 16'h0040);
        push_mem(1'b0, 16'h0140);
        cpu_op(1'b1, 1'b0, 16'h0148, 32'h0, "t3_rd", lat);
        check("t3_wb_w2", LB'(last_wb[95:64]), LB'(32'hDEAD_BEEF));
        check("t3_wb_w0", LB'(last_wb[31:0]), LB'(32'h1000_0002));
        check("t3_rdata", LB'(bus.cpu_rdata), LB'(32'h1000_000A));
        check("t3_cnt", LB'({bus.hit_count, bus.miss_count}), LB'({16'd2, 16'd2}));

        // T4: read and write together -> write wins (write-allocate miss)
        push_mem(1'b0, 16'h0060);
        cpu_op(1'b1, 1'b1, 16'h0060, 32'h1234_5678, "t4_both", lat);
        cpu_op(1'b1, 1'b0, 16'h0060, 32'h0, "t4_rd", lat);
        check("t4_rdata", LB'(bus.cpu_rdata), LB'(32'h1234_5678));
        check("t4_cnt", LB'({bus.hit_count, bus.miss_count}), LB'({16'd3, 16'd3}));
        check("t4_memq", LB'(mem_q.size()), '0);

        // T5: reset while waiting for fill data
        push_mem(1'b0, 16'h0080);
        @(negedge clk);
        bus.cpu_addr = 16'h0080;
        bus.cpu_read = 1'b1;
        lat = 0;
        while (!bus.mem_read && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("t5_fill_req", LB'(bus.mem_read), LB'(1));
        @(negedge clk);
        rst = 1'b1;
        bus.cpu_read = 1'b0;
        #1;
        check_idle_outputs("t5_rst");
        repeat (2) @(negedge clk);
        check("t5_no_ready", LB'(bus.cpu_ready), '0);
        rst = 1'b0;
        push_mem(1'b0, 16'h0080);
        cpu_op(1'b1, 1'b0, 16'h0080, 32'h0, "t5_rd80", lat);
        push_mem(1'b0, 16'h0140);
        cpu_op(1'b1, 1'b0, 16'h0140, 32'h0, "t5_rd140", lat);
        check("t5_cnt", LB'({bus.hit_count, bus.miss_count}), LB'({16'd0, 16'd2}));

        // T6: hold a hitting read for 9 edges -> accepted every third edge
        p0 = pulse_cnt;
        s0 = pulse_cyc.size();
        @(negedge clk);
        bus.cpu_addr = 16'h0084;
        bus.cpu_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_exp_t e;
            e.is_read = 1'b1;
            e.data    = ref_mem[14'h0021];
            e.tag     = "t6_rd";
            cpu_q.push_back(e);
        end
        repeat (9) @(negedge clk);
        bus.cpu_read = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_pulses", LB'(pulse_cnt - p0), LB'(3));
        for (int i = 0; i + 1 < pulse_cyc.size() - s0; i++)
            check("t6_gap", LB'(pulse_cyc[s0+i+1] - pulse_cyc[s0+i]), LB'(3));
        check("t6_hits", LB'(bus.hit_count), LB'(3));

        check("cpu_q_empty", LB'(cpu_q.size()), '0);
        check("mem_q_empty", LB'(mem_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
